dte_multi_chan: RTL and testbench
=================================

// Module: dte_multi_chan
// PURPOSE
//  Parametrised multi-channel DTE front-end transfer engine: NCHAN front-end (-11) channels buffer
//  36-bit words toward the KL10 (-10) side through per-channel FIFOs. A round-robin arbiter presents
//  one word at a time on a single -10 word port, gated by a per-channel word count programmed by -10.
//  Adds per-channel doorbell and done flags. Sits between the front-end model and the EBUS/DTE logic.
// PARAMETERS
//  NCHAN   4   number of independent DTE channels (>=2)
//  WORD_W  36  word width
//  DEPTH   8   per-channel FIFO depth in words (power of 2, >=2)
//  CNT_W   12  width of per-channel word counter
// PORTS
//  clk              in   1              system clock, all state on posedge
//  CROBAR_N         in   1              async active-low reset
//  fe_wr_valid      in   NCHAN          front-end word valid, per channel
//  fe_wr_data       in   NCHAN*WORD_W   front-end word, channel c at [c*WORD_W +: WORD_W]
//  fe_wr_ready      out  NCHAN          channel FIFO not full
//  fe_doorbell      in   NCHAN          1-cycle pulse: front-end rings -10 doorbell
//  k_req            out  1              word presented to -10
//  k_chan           out  $clog2(NCHAN)  channel of presented word
//  k_data           out  WORD_W         presented word
//  k_ack            in   1              -10 accepts presented word
//  k_cnt_load       in   1              load word count for k_cnt_chan
//  k_cnt_chan       in   $clog2(NCHAN)  channel for count load
//  k_cnt_val        in   CNT_W          word count to load
//  k_doorbell       out  NCHAN          sticky doorbell flags
//  k_done           out  NCHAN          sticky transfer-complete flags
//  k_flag_clr       in   NCHAN          clear doorbell and done flags of selected channels
// BEHAVIOUR
//  Reset (CROBAR_N=0, async): FIFOs empty, counts 0, k_req=0, k_chan=0, k_data=0, k_doorbell=0,
//   k_done=0, fe_wr_ready=all 1 on first clock after release; arbiter pointer = channel 0.
//  FIFO write: fe_wr_valid[c]&&fe_wr_ready[c] pushes word; full -> ready low, word not taken.
//  Eligible channel: FIFO non-empty AND count!=0.
//  FSM IDLE: if any eligible, pick first eligible at/after pointer (wrap NCHAN-1 -> 0), pop word into
//   output register, k_req=1 next cycle -> PRESENT. Latency: word written to empty FIFO of an
//   eligible channel while IDLE -> k_req high 2 cycles later.
//  PRESENT: k_req, k_chan, k_data held stable until k_ack. On k_ack: count[chan]-=1; if result 0 set
//   k_done[chan]; pointer = chan+1 (wrap); -> IDLE (k_req low next cycle; no back-to-back present).
//  Count load: count[k_cnt_chan]=k_cnt_val, takes effect next cycle, any state. Load and k_ack on
//   same channel same cycle: load wins, no decrement, done not set. Load 0 on channel in PRESENT:
//   current word still completes; no decrement below 0 (count saturates at 0, done not re-set).
//  Count 0: words stay in FIFO, not presented; front-end back-pressured once full.
//  Flags: fe_doorbell[c] sets k_doorbell[c]; done event sets k_done[c]; k_flag_clr[c] clears both.
//   Set and clear same cycle: set wins.
//  Simultaneous FIFO push and arbiter pop on same channel: both occur, occupancy unchanged.
// STRUCTURE
//  dte_pkg: typedef logic [35:0] w36_t; chan index typedef; FSM enum {IDLE, PRESENT}.
//  Sub-module dte_fifo (WORD_W, DEPTH): sync FIFO push/pop/full/empty, instanced NCHAN times
//   by generate loop. Arbiter, counters, flags and FSM live in dte_multi_chan.
// TESTING
//  1 Reset: assert CROBAR_N=0 mid-PRESENT -> k_req=0, k_done=0, k_doorbell=0 immediately; FIFOs empty.
//  2 Single: load ch1 count=2, push 36'o123 then 36'o456 on ch1, ack each -> k_chan=1 data in order,
//    k_done[1]=1 after second ack, FIFO still accepts words, third word not presented.
//  3 Round-robin: counts 4 on ch0..ch3, two words each, k_ack always 1 -> k_chan 0,1,2,3,0,1,2,3.
//  4 Back-pressure: ch2 count=0, push DEPTH=8 words -> fe_wr_ready[2]=0 after 8th; load count=8 ->
//    all 8 drain in order, ready returns 1 after first pop.
//  5 Collisions: k_cnt_load ch0 val=5 same cycle as k_ack ch0 -> count=5, no done; fe_doorbell[3]
//    and k_flag_clr[3] same cycle -> k_doorbell[3]=1.
//  6 Stability: hold k_ack=0 for 20 cycles in PRESENT -> k_req/k_chan/k_data unchanged throughout.

Source files
------------

// File: rtl/dte_multi_chan_pkg.sv
// Shared types and defaults for the multi-channel DTE transfer engine.
package dte_multi_chan_pkg;

   localparam int NCHAN_DEF  = 4;
   localparam int WORD_W_DEF = 36;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 12;
   localparam int CHAN_W_DEF = $clog2(NCHAN_DEF);

   // One PDP-10 word.
   typedef logic [35:0] w36_t;

   // Channel index at the default channel count.
   typedef logic [CHAN_W_DEF-1:0] chan_t;

   // Presentation FSM: either looking for work or holding a word for the -10.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } dte_state_e;

   // Next channel index with wrap from n-1 back to 0.
   function automatic int wrap_inc(input int idx, input int n);
      if (idx + 1 >= n) begin
         return 0;
      end else begin
         return idx + 1;
      end
   endfunction

endpackage

// File: rtl/dte_multi_chan_if.sv
// Front-end / -10 side signal bundle of the DTE transfer engine.
interface dte_multi_chan_if #(
   parameter int NCHAN  = 4,
   parameter int WORD_W = 36,
   parameter int CNT_W  = 12
);
   localparam int CHAN_W = $clog2(NCHAN);

   // front-end (-11) side
   logic [NCHAN-1:0]        fe_wr_valid;
   logic [NCHAN*WORD_W-1:0] fe_wr_data;
   logic [NCHAN-1:0]        fe_wr_ready;
   logic [NCHAN-1:0]        fe_doorbell;

   // -10 side
   logic                    k_req;
   logic [CHAN_W-1:0]       k_chan;
   logic [WORD_W-1:0]       k_data;
   logic                    k_ack;
   logic                    k_cnt_load;
   logic [CHAN_W-1:0]       k_cnt_chan;
   logic [CNT_W-1:0]        k_cnt_val;
   logic [NCHAN-1:0]        k_doorbell;
   logic [NCHAN-1:0]        k_done;
   logic [NCHAN-1:0]        k_flag_clr;

   // Environment side: drives the front-end words and the -10 controls.
   modport master (
      output fe_wr_valid, fe_wr_data, fe_doorbell,
      output k_ack, k_cnt_load, k_cnt_chan, k_cnt_val, k_flag_clr,
      input  fe_wr_ready, k_req, k_chan, k_data, k_doorbell, k_done
   );

   // Engine side.
   modport slave (
      input  fe_wr_valid, fe_wr_data, fe_doorbell,
      input  k_ack, k_cnt_load, k_cnt_chan, k_cnt_val, k_flag_clr,
      output fe_wr_ready, k_req, k_chan, k_data, k_doorbell, k_done
   );

endinterface

// File: rtl/dte_multi_chan_fifo.sv
// Per-channel synchronous FIFO with registered full/empty flags.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module dte_fifo #(
   parameter int WORD_W = 36,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic [WORD_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]             occ_q, occ_d;
   logic                         full_q, full_d;
   logic                         empty_q, empty_d;
   logic                         do_push_s, do_pop_s;

   // Next-state for storage, pointers, occupancy and flags.
   always_comb begin
      do_push_s = push_i & ~full_q;
      do_pop_s  = pop_i & ~empty_q;
      mem_d     = mem_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase
      full_d  = (occ_d == OCC_FULL);
      empty_d = (occ_d == {OCC_W{1'b0}});
   end

   // State registers; full reads high while in reset so the front-end is
   // held off until the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         full_q   <= 1'b1;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = empty_q;

endmodule

// File: rtl/dte_multi_chan.sv
// Multi-channel DTE transfer engine: per-channel FIFOs from the front-end,
// a round-robin arbiter presenting one word at a time to the -10, gated by
// per-channel word counts, plus sticky doorbell and done flags.
module dte_multi_chan
   import dte_multi_chan_pkg::*;
#(
   parameter int NCHAN  = NCHAN_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic              clk,
   input logic              CROBAR_N,
   dte_multi_chan_if.slave  bus
);

   localparam int CHAN_W = $clog2(NCHAN);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [NCHAN-1:0]             full_s, empty_s, pop_s, elig_s;
   logic [NCHAN-1:0][WORD_W-1:0] rd_data_s;
   logic                         found_s;
   logic [CHAN_W-1:0]            pick_s;
   logic [NCHAN-1:0]             done_set_s;

   dte_state_e                   state_q, state_d;
   logic [CHAN_W-1:0]            ptr_q, ptr_d;
   logic [NCHAN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic                         req_q, req_d;
   logic [CHAN_W-1:0]            chan_q, chan_d;
   logic [WORD_W-1:0]            data_q, data_d;
   logic [NCHAN-1:0]             doorbell_q, doorbell_d;
   logic [NCHAN-1:0]             done_q, done_d;

   for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      dte_fifo #(
         .WORD_W (WORD_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (CROBAR_N),
         .push_i    (bus.fe_wr_valid[c]),
         .pop_i     (pop_s[c]),
         .wr_data_i (bus.fe_wr_data[c*WORD_W +: WORD_W]),
         .rd_data_o (rd_data_s[c]),
         .full_o    (full_s[c]),
         .empty_o   (empty_s[c])
      );
   end

   // Eligibility and round-robin pick: first eligible channel at/after ptr.
   always_comb begin
      int idx;
      idx     = 0;
      found_s = 1'b0;
      pick_s  = '0;
      for (int c = 0; c < NCHAN; c++) begin
         elig_s[c] = ~empty_s[c] & (cnt_q[c] != CNT_ZERO);
      end
      for (int i = 0; i < NCHAN; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NCHAN) begin
            idx = idx - NCHAN;
         end else begin
            idx = idx;
         end
         if (!found_s && elig_s[CHAN_W'(idx)]) begin
            found_s = 1'b1;
            pick_s  = CHAN_W'(idx);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Presentation FSM, word counters and done events.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      req_d      = req_q;
      chan_d     = chan_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      pop_s      = '0;
      done_set_s = '0;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               pop_s[pick_s] = 1'b1;
               chan_d        = pick_s;
               data_d        = rd_data_s[pick_s];
               req_d         = 1'b1;
               state_d       = PRESENT;
            end else begin
               req_d         = 1'b0;
            end
         end
         PRESENT: begin
            if (bus.k_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
               ptr_d   = CHAN_W'(wrap_inc(int'(chan_q), NCHAN));
               // A count load to the same channel overrides the decrement;
               // a count already at zero stays there without a new done.
               if (!(bus.k_cnt_load && (bus.k_cnt_chan == chan_q)) &&
                   (cnt_q[chan_q] != CNT_ZERO)) begin
                  cnt_d[chan_q] = cnt_q[chan_q] - CNT_ONE;
                  if (cnt_q[chan_q] == CNT_ONE) begin
                     done_set_s[chan_q] = 1'b1;
                  end else begin
                     done_set_s[chan_q] = 1'b0;
                  end
               end else begin
                  cnt_d[chan_q] = cnt_q[chan_q];
               end
            end else begin
               state_d = PRESENT;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
      if (bus.k_cnt_load) begin
         cnt_d[bus.k_cnt_chan] = bus.k_cnt_val;
      end else begin
         cnt_d = cnt_d;
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_comb begin
      doorbell_d = (doorbell_q & ~bus.k_flag_clr) | bus.fe_doorbell;
      done_d     = (done_q & ~bus.k_flag_clr) | done_set_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge CROBAR_N) begin
      if (!CROBAR_N) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         chan_q     <= '0;
         data_q     <= '0;
         doorbell_q <= '0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         chan_q     <= chan_d;
         data_q     <= data_d;
         doorbell_q <= doorbell_d;
         done_q     <= done_d;
      end
   end

   assign bus.fe_wr_ready = ~full_s;
   assign bus.k_req       = req_q;
   assign bus.k_chan      = chan_q;
   assign bus.k_data      = data_q;
   assign bus.k_doorbell  = doorbell_q;
   assign bus.k_done      = done_q;

endmodule

// File: tb/tb_dte_multi_chan.sv
// Directed self-checking bench for dte_multi_chan.
module tb_dte_multi_chan;
   import dte_multi_chan_pkg::*;

   logic clk;
   logic crobar_n;
   int   tests;
   int   fails;

   dte_multi_chan_if #(.NCHAN(4), .WORD_W(36), .CNT_W(12)) bus ();

   dte_multi_chan #(.NCHAN(4), .WORD_W(36), .DEPTH(8), .CNT_W(12)) dut (
      .clk      (clk),
      .CROBAR_N (crobar_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish, failures so far %0d", fails);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input int c, input w36_t w);
      bus.fe_wr_valid         = 4'b0000;
      bus.fe_wr_valid[c]      = 1'b1;
      bus.fe_wr_data[c*36 +: 36] = w;
      tick();
      bus.fe_wr_valid         = 4'b0000;
   endtask

   task automatic load(input int c, input logic [11:0] v);
      bus.k_cnt_load = 1'b1;
      bus.k_cnt_chan = 2'(c);
      bus.k_cnt_val  = v;
      tick();
      bus.k_cnt_load = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int g;
      g = 0;
      while (bus.k_req !== 1'b1 && g < 16) begin
         tick();
         g++;
      end
      check(tag, 64'(bus.k_req), 64'd1);
   endtask

   logic [1:0] rr_chan [8];
   w36_t       rr_data [8];

   initial begin
      tests = 0;
      fails = 0;
      crobar_n        = 1'b0;
      bus.fe_wr_valid = 4'b0000;
      bus.fe_wr_data  = 144'd0;
      bus.fe_doorbell = 4'b0000;
      bus.k_ack       = 1'b0;
      bus.k_cnt_load  = 1'b0;
      bus.k_cnt_chan  = 2'd0;
      bus.k_cnt_val   = 12'd0;
      bus.k_flag_clr  = 4'b0000;
      rr_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      rr_data = '{36'o100, 36'o101, 36'o102, 36'o103, 36'o110, 36'o111, 36'o112, 36'o113};

      // ---- reset state
      #2;
      check("rst_req",      64'(bus.k_req), 64'd0);
      check("rst_chan",     64'(bus.k_chan), 64'd0);
      check("rst_data",     64'(bus.k_data), 64'd0);
      check("rst_doorbell", 64'(bus.k_doorbell), 64'd0);
      check("rst_done",     64'(bus.k_done), 64'd0);
      tick();
      crobar_n = 1'b1;
      tick();
      check("rst_ready", 64'(bus.fe_wr_ready), 64'hF);

      // ---- single channel, count 2
      load(1, 12'd2);
      push1(1, 36'o123);
      check("s_latency_req0", 64'(bus.k_req), 64'd0);
      tick();
      check("s_w1_req",  64'(bus.k_req), 64'd1);
      check("s_w1_chan", 64'(bus.k_chan), 64'd1);
      check("s_w1_data", 64'(bus.k_data), 64'o123);
      bus.k_ack = 1'b1;
      push1(1, 36'o456);
      bus.k_ack = 1'b0;
      check("s_ack1_req",  64'(bus.k_req), 64'd0);
      check("s_ack1_done", 64'(bus.k_done), 64'd0);
      tick();
      check("s_w2_req",  64'(bus.k_req), 64'd1);
      check("s_w2_chan", 64'(bus.k_chan), 64'd1);
      check("s_w2_data", 64'(bus.k_data), 64'o456);
      bus.k_ack = 1'b1;
      tick();
      bus.k_ack = 1'b0;
      check("s_ack2_req",  64'(bus.k_req), 64'd0);
      check("s_ack2_done", 64'(bus.k_done), 64'b0010);
      push1(1, 36'o777);
      check("s_w3_ready", 64'(bus.fe_wr_ready[1]), 64'd1);
      tick();
      tick();
      check("s_w3_not_presented", 64'(bus.k_req), 64'd0);

      // ---- stability while presenting, doorbell set
      load(1, 12'd1);
      tick();
      check("st_req",  64'(bus.k_req), 64'd1);
      check("st_chan", 64'(bus.k_chan), 64'd1);
      check("st_data", 64'(bus.k_data), 64'o777);
      bus.fe_doorbell = 4'b0001;
      tick();
      bus.fe_doorbell = 4'b0000;
      check("st_doorbell", 64'(bus.k_doorbell), 64'b0001);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("st_hold_req",  64'(bus.k_req), 64'd1);
         check("st_hold_chan", 64'(bus.k_chan), 64'd1);
         check("st_hold_data", 64'(bus.k_data), 64'o777);
      end

      // ---- async reset in the middle of PRESENT
      check("r_pre_done", 64'(bus.k_done), 64'b0010);
      #2;
      crobar_n = 1'b0;
      #1;
      check("r_req",      64'(bus.k_req), 64'd0);
      check("r_done",     64'(bus.k_done), 64'd0);
      check("r_doorbell", 64'(bus.k_doorbell), 64'd0);
      tick();
      tick();
      crobar_n = 1'b1;
      tick();
      check("r_ready", 64'(bus.fe_wr_ready), 64'hF);
      load(1, 12'd3);
      tick();
      tick();
      tick();
      check("r_fifo_empty", 64'(bus.k_req), 64'd0);

      // ---- round robin, ack held high
      bus.k_ack = 1'b1;
      load(0, 12'd4);
      load(1, 12'd4);
      load(2, 12'd4);
      load(3, 12'd4);
      bus.fe_wr_valid = 4'b1111;
      bus.fe_wr_data  = {36'o103, 36'o102, 36'o101, 36'o100};
      tick();
      bus.fe_wr_data  = {36'o113, 36'o112, 36'o111, 36'o110};
      tick();
      bus.fe_wr_valid = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         wait_req("rr_req");
         check("rr_chan", 64'(bus.k_chan), 64'(rr_chan[k]));
         check("rr_data", 64'(bus.k_data), 64'(rr_data[k]));
         tick();
      end
      bus.k_ack = 1'b0;
      check("rr_done", 64'(bus.k_done), 64'd0);

      // ---- back-pressure on channel 2
      load(2, 12'd0);
      for (int i = 0; i < 8; i++) begin
         push1(2, 36'o200 + 36'(i));
         if (i == 6) begin
            check("bp_ready_7", 64'(bus.fe_wr_ready[2]), 64'd1);
         end
      end
      check("bp_ready_full", 64'(bus.fe_wr_ready[2]), 64'd0);
      check("bp_no_req",     64'(bus.k_req), 64'd0);
      push1(2, 36'o777);
      check("bp_ready_still", 64'(bus.fe_wr_ready[2]), 64'd0);
      bus.k_ack = 1'b1;
      load(2, 12'd8);
      for (int i = 0; i < 8; i++) begin
         wait_req("bp_req");
         check("bp_chan", 64'(bus.k_chan), 64'd2);
         check("bp_data", 64'(bus.k_data), 64'o200 + 64'(i));
         if (i == 0) begin
            check("bp_ready_back", 64'(bus.fe_wr_ready[2]), 64'd1);
         end
         tick();
      end
      check("bp_done", 64'(bus.k_done), 64'b0100);
      tick();
      tick();
      check("bp_9th_dropped", 64'(bus.k_req), 64'd0);
      bus.k_ack = 1'b0;
      bus.k_flag_clr = 4'b1111;
      tick();
      bus.k_flag_clr = 4'b0000;
      check("clr_all", 64'(bus.k_done), 64'd0);

      // ---- count load colliding with ack on channel 0
      load(0, 12'd1);
      push1(0, 36'o55);
      tick();
      check("c_req",  64'(bus.k_req), 64'd1);
      check("c_data", 64'(bus.k_data), 64'o55);
      bus.k_ack      = 1'b1;
      bus.k_cnt_load = 1'b1;
      bus.k_cnt_chan = 2'd0;
      bus.k_cnt_val  = 12'd5;
      tick();
      bus.k_ack      = 1'b0;
      bus.k_cnt_load = 1'b0;
      check("c_no_done", 64'(bus.k_done), 64'd0);
      for (int j = 0; j < 5; j++) begin
         push1(0, 36'o60 + 36'(j));
      end
      bus.k_ack = 1'b1;
      for (int j = 0; j < 5; j++) begin
         wait_req("c5_req");
         check("c5_data", 64'(bus.k_data), 64'o60 + 64'(j));
         if (j == 4) begin
            check("c5_done_before", 64'(bus.k_done[0]), 64'd0);
         end
         tick();
      end
      bus.k_ack = 1'b0;
      check("c5_done_after", 64'(bus.k_done), 64'b0001);

      // ---- doorbell set and clear in the same cycle
      bus.fe_doorbell = 4'b1000;
      bus.k_flag_clr  = 4'b1000;
      tick();
      bus.fe_doorbell = 4'b0000;
      bus.k_flag_clr  = 4'b0000;
      check("db_set_wins", 64'(bus.k_doorbell), 64'b1000);
      bus.k_flag_clr = 4'b1111;
      tick();
      bus.k_flag_clr = 4'b0000;
      check("db_cleared",   64'(bus.k_doorbell), 64'd0);
      check("done_cleared", 64'(bus.k_done), 64'd0);

      // ---- count loaded to 0 while presenting on channel 1
      load(1, 12'd2);
      push1(1, 36'o321);
      tick();
      check("z_req", 64'(bus.k_req), 64'd1);
      load(1, 12'd0);
      check("z_hold_data", 64'(bus.k_data), 64'o321);
      bus.k_ack = 1'b1;
      tick();
      bus.k_ack = 1'b0;
      check("z_req_low", 64'(bus.k_req), 64'd0);
      check("z_no_done", 64'(bus.k_done), 64'd0);
      push1(1, 36'o322);
      tick();
      tick();
      check("z_not_presented", 64'(bus.k_req), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
